tt_capture: RTL
===============

TT_CAPTURE -- requirements
Module: tt_capture

Interface
REQ-001 SHALL have parameter SETTLE, default 1: cycles each input vector is held before f_in is sampled; legal range 1..255.
REQ-002 SHALL have parameter EXPECTED, default 128'h0: reference truth table, used only by the check feature.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: capture request, level-sampled.
REQ-006 SHALL have port abort, input, 1 bit: cancels the capture in progress.
REQ-007 SHALL have ports x0..x6, output, 1 bit each: input vector driven to the external 7-input function under test.
REQ-008 SHALL have port f_in, input, 1 bit: function output returned by the function under test.
REQ-009 SHALL have port busy, output, 1 bit: a capture is in progress.
REQ-010 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-011 SHALL have port tt, output, 128 bits: captured truth table.
REQ-012 SHALL have port tt_valid, output, 1 bit: tt holds a complete capture.
REQ-013 SHALL have port match, output, 1 bit: tt equals EXPECTED; driven only when the check feature is compiled in.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-015 SHALL, in IDLE with start=1, load the 7-bit index idx=0, clear tt_valid, and enter DRIVE at the next edge.
REQ-016 SHALL drive {x6..x0}=idx from a register throughout DRIVE and SAMPLE, with x0 as the LSB; outputs SHALL be glitch-free.
REQ-017 SHALL stay in DRIVE for exactly SETTLE cycles, then spend 1 cycle in SAMPLE.
REQ-018 SHALL, at the end of SAMPLE, write tt[idx]=f_in; then enter DRIVE with idx+1 if idx<127, or enter DONE if idx==127. idx SHALL never wrap.
REQ-019 SHALL assert done for exactly the one DONE cycle, set tt_valid in that same cycle, and return to IDLE at the next edge.
REQ-020 SHALL take 128*(SETTLE+1) cycles from the first DRIVE cycle to the DONE cycle; with SETTLE=1 this is 256 cycles.
REQ-021 SHALL assert busy in DRIVE and SAMPLE only.
REQ-022 SHALL ignore start while busy=1 or in DONE; a start held high in IDLE after DONE SHALL begin a new capture.
REQ-023 SHALL, when abort=1 in DRIVE or SAMPLE, go to IDLE at the next edge with tt_valid=0, no done pulse, and tt bits left as partially written.
REQ-024 SHALL give abort priority over start when both are 1 in the same cycle; abort in IDLE or DONE SHALL have no effect.
REQ-025 SHALL hold tt and tt_valid stable in IDLE until the next accepted start.
REQ-026 SHALL produce a tt whose hex string has tt[127] as its most significant bit, i.e. tt[i]=f(x=i).

Reset
REQ-027 SHALL, on rst=1 at any time including mid-capture, immediately force: state=IDLE, idx=0, x0..x6=0, busy=0, done=0, tt=0, tt_valid=0, match=0.
REQ-028 SHALL, after rst deasserts, accept start no earlier than the first rising edge.

Configuration
REQ-029 SHALL, with macro TT_CAPTURE_CHECK_EN defined, register match=(tt==EXPECTED) in the DONE cycle, valid while tt_valid=1, and clear it on an accepted start or on abort.
REQ-030 SHALL, without TT_CAPTURE_CHECK_EN, keep the match port present, tie it to 0, and contain no comparator logic.

Structure
REQ-031 SHALL place the following in shared package tt_capture_pkg: constants N_IN=7 and TT_W=128, and the FSM state enum typedef.
REQ-032 SHALL implement the SETTLE counter as the single sub-module tt_settle_timer (load, count, expire); all other logic SHALL be inline.

Verification
REQ-033 SHALL cover: f_in tied to 0, SETTLE=1 -> done 256 cycles after the first DRIVE cycle, tt=128'h0, tt_valid=1.
REQ-034 SHALL cover: f_in=x0 -> tt=128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA; f_in=x6 -> tt=128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000.
REQ-035 SHALL cover: combinational model maj(x0, maj(x1, maj(x4,x5,x6), maj(x0,x2,x3)), maj(x4, maj(x1,x2,x3), maj(x0,x5,x6))) with EXPECTED=128'hfeeefee8feeaa880feeaa880e8808880 and TT_CAPTURE_CHECK_EN defined -> match=1; flip one EXPECTED bit -> match=0.
REQ-036 SHALL cover: SETTLE=3 with a model of 2-cycle f_in latency -> correct table, done 512 cycles after the first DRIVE cycle.
REQ-037 SHALL cover: abort at idx=64 -> IDLE next edge, no done, tt_valid=0; a subsequent start gives a full correct capture.
REQ-038 SHALL cover: start pulsed at idx=10, and rst asserted at idx=100 -> the start has no effect; rst forces all outputs to 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/tt_capture_pkg.sv
// Shared constants and FSM state type for the truth-table capture block.
package tt_capture_pkg;

  localparam int N_IN  = 7;
  localparam int TT_W  = 128;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle counter: reloads to SETTLE-1 while load is high, counts down while count is high.
module tt_settle_timer
  import tt_capture_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= RELOAD;
    end else if (load) begin
      cnt_reg <= RELOAD;
    end else if (count && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  // Expires on the last of the SETTLE counting cycles.
  assign expire = count && (cnt_reg == '0);

endmodule

// File: rtl/tt_capture.sv
// Captures the 128-entry truth table of an external 7-input function.
// Optional reference compare of the table against EXPECTED is enabled by TT_CAPTURE_CHECK_EN.
module tt_capture
  import tt_capture_pkg::*;
#(
  parameter int             SETTLE   = 1,
  parameter logic [127:0]   EXPECTED = 128'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  output logic         x0,
  output logic         x1,
  output logic         x2,
  output logic         x3,
  output logic         x4,
  output logic         x5,
  output logic         x6,
  input  logic         f_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] tt,
  output logic         tt_valid,
  output logic         match
);

  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TT_W - 1);

  state_t            state_reg;
  logic [N_IN-1:0]   idx_reg;
  logic [TT_W-1:0]   tt_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              valid_reg;
  logic              expire;
  logic              in_drive;
  logic              abort_hit;

  assign in_drive  = (state_reg == DRIVE);
  assign abort_hit = abort && ((state_reg == DRIVE) || (state_reg == SAMPLE));

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .load   (!in_drive),
    .count  (in_drive),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      tt_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            idx_reg   <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= DRIVE;
          end
        end
        DRIVE: begin
          if (abort) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (expire) begin
            state_reg <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            tt_reg[idx_reg] <= f_in;
            if (idx_reg == LAST_IDX) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              valid_reg <= 1'b1;
              state_reg <= DONE;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= DRIVE;
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef TT_CAPTURE_CHECK_EN
  logic match_reg;

  // The last sample lands in bit 127, so compare with it merged in to be ready in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_reg <= 1'b0;
    end else if ((state_reg == IDLE) && start) begin
      match_reg <= 1'b0;
    end else if (abort_hit) begin
      match_reg <= 1'b0;
    end else if ((state_reg == SAMPLE) && (idx_reg == LAST_IDX)) begin
      match_reg <= ({f_in, tt_reg[TT_W-2:0]} == EXPECTED);
    end
  end

  assign match = match_reg;
`else
  assign match = 1'b0;
`endif

  assign x0       = idx_reg[0];
  assign x1       = idx_reg[1];
  assign x2       = idx_reg[2];
  assign x3       = idx_reg[3];
  assign x4       = idx_reg[4];
  assign x5       = idx_reg[5];
  assign x6       = idx_reg[6];
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign tt       = tt_reg;
  assign tt_valid = valid_reg;

endmodule
